adaptive_clk_ctrl: RTL and testbench

//  Parametrised, self-contained adaptive clock controller: a glitch-free variable clock divider

---
 rtl/adaptive_clk_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_adaptive_clk_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/adaptive_clk_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adaptive_clk_ctrl
// Purpose  : Glitch-free variable clock divider plus an error-driven search
//            for the smallest error-free divider (with safety margin).
//            Define ACM_BINARY_SEARCH_EN for binary instead of linear search.
// Revision : 1.0 - initial release
// ============================================================================
module adaptive_clk_ctrl #(
    parameter int DIV_WIDTH     = 8,
    parameter int DIV_MIN       = 0,
    parameter int DIV_MAX       = 15,
    parameter int SETTLE_CYCLES = 4,
    parameter int CHECK_CYCLES  = 8,
    parameter int MARGIN        = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_Start,
    input  logic                 i_Error_Flag,
    output logic                 o_Clk_Var,
    output logic                 o_Clk_En,
    output logic [DIV_WIDTH-1:0] o_Clk_Div,
    output logic                 o_Busy,
    output logic                 o_Done,
    output logic                 o_Fail,
    output logic [7:0]           o_Trials
);
    localparam logic [DIV_WIDTH-1:0] c_div_min = DIV_WIDTH'(DIV_MIN);
    localparam logic [DIV_WIDTH-1:0] c_div_max = DIV_WIDTH'(DIV_MAX);
    localparam int c_ph_max = (SETTLE_CYCLES > CHECK_CYCLES) ? SETTLE_CYCLES : CHECK_CYCLES;
    localparam int c_ph_w   = (c_ph_max > 1) ? $clog2(c_ph_max) : 1;
    localparam logic [c_ph_w-1:0] c_settle_last = c_ph_w'(SETTLE_CYCLES - 1);
    localparam logic [c_ph_w-1:0] c_check_last  = c_ph_w'(CHECK_CYCLES - 1);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_apply  = 3'd1;
    localparam logic [2:0] c_st_settle = 3'd2;
    localparam logic [2:0] c_st_check  = 3'd3;
    localparam logic [2:0] c_st_adjust = 3'd4;
    localparam logic [2:0] c_st_final  = 3'd5;
    localparam logic [2:0] c_st_done   = 3'd6;

    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DIV_WIDTH-1:0] r_div_active;
    logic [DIV_WIDTH-1:0] r_div_pending;
    logic                 r_clk_var;
    logic                 r_clk_en;
    logic                 w_toggle;

    logic [2:0]           r_state;
    logic [2:0]           w_state_n;
    logic [DIV_WIDTH-1:0] r_trial;
    logic [c_ph_w-1:0]    r_ph;
    logic                 r_err;
    logic                 r_fail;
    logic [7:0]           r_trials;

    logic                 w_pass;
    logic                 w_adj_fail;
    logic                 w_adj_done;
    logic [DIV_WIDTH-1:0] w_adj_trial;
    logic [DIV_WIDTH-1:0] w_best;
    logic [DIV_WIDTH:0]   w_best_sum;
    logic [DIV_WIDTH-1:0] w_final;
`ifdef ACM_BINARY_SEARCH_EN
    logic [DIV_WIDTH-1:0] r_lo;
    logic [DIV_WIDTH-1:0] r_hi;
    logic [DIV_WIDTH-1:0] w_lo_n;
    logic [DIV_WIDTH-1:0] w_hi_n;
    logic [DIV_WIDTH:0]   w_mid_sum;
`else
    logic [DIV_WIDTH-1:0] r_best;
`endif

    // New divider values only take effect at a toggle, so no phase is ever truncated
    assign w_toggle = (r_cnt >= r_div_active);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_clk_var    <= 1'b1;
            r_clk_en     <= 1'b0;
            r_div_active <= c_div_max;
        end else begin
            r_clk_en <= 1'b0;
            if (w_toggle) begin
                r_cnt        <= '0;
                r_clk_var    <= ~r_clk_var;
                r_clk_en     <= ~r_clk_var;
                r_div_active <= r_div_pending;
            end else begin
                r_cnt <= r_cnt + DIV_WIDTH'(1);
            end
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_pass      = ~r_err;
        w_adj_fail  = r_err && (r_trial == c_div_max);
        w_adj_done  = 1'b0;
        w_adj_trial = r_trial;
        w_best      = r_trial;
`ifdef ACM_BINARY_SEARCH_EN
        w_lo_n = r_lo;
        w_hi_n = r_hi;
        if (w_pass) w_hi_n = r_trial;
        else        w_lo_n = r_trial + DIV_WIDTH'(1);
        w_mid_sum = {1'b0, w_lo_n} + {1'b0, w_hi_n};
        if (w_lo_n < w_hi_n) begin
            w_adj_trial = w_mid_sum[DIV_WIDTH:1];
        end else begin
            w_adj_done = 1'b1;
            w_best     = w_hi_n;
        end
`else
        if (!w_pass) begin
            w_adj_done = 1'b1;
            w_best     = r_best;
        end else if (r_trial > c_div_min) begin
            w_adj_trial = r_trial - DIV_WIDTH'(1);
        end else begin
            w_adj_done = 1'b1;
        end
`endif
        // One extra bit so best+MARGIN cannot wrap before the clamp
        w_best_sum = {1'b0, w_best} + (DIV_WIDTH + 1)'(MARGIN);
        if (w_adj_fail || (w_best_sum > {1'b0, c_div_max})) w_final = c_div_max;
        else                                                 w_final = w_best_sum[DIV_WIDTH-1:0];

        case (r_state)
            c_st_idle, c_st_done: if (i_Start) w_state_n = c_st_apply;
            c_st_apply:  if (r_div_active == r_trial) w_state_n = c_st_settle;
            c_st_settle: if (r_ph == c_settle_last)   w_state_n = c_st_check;
            c_st_check:  if (r_ph == c_check_last)    w_state_n = c_st_adjust;
            c_st_adjust: w_state_n = (w_adj_done || w_adj_fail) ? c_st_final : c_st_apply;
            c_st_final:  if (r_div_active == r_trial) w_state_n = c_st_done;
            default:     w_state_n = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_trial       <= c_div_max;
            r_div_pending <= c_div_max;
            r_ph          <= '0;
            r_err         <= 1'b0;
            r_fail        <= 1'b0;
            r_trials      <= 8'd0;
`ifdef ACM_BINARY_SEARCH_EN
            r_lo          <= c_div_min;
            r_hi          <= c_div_max;
`else
            r_best        <= c_div_max;
`endif
        end else begin
            r_state <= w_state_n;
            case (r_state)
                c_st_idle, c_st_done: begin
                    if (i_Start) begin
                        r_trial       <= c_div_max;
                        r_div_pending <= c_div_max;
                        r_trials      <= 8'd1;
                        r_fail        <= 1'b0;
                        r_err         <= 1'b0;
`ifdef ACM_BINARY_SEARCH_EN
                        r_lo          <= c_div_min;
                        r_hi          <= c_div_max;
`endif
                    end
                end
                c_st_settle: r_ph <= (r_ph == c_settle_last) ? '0 : r_ph + c_ph_w'(1);
                c_st_check: begin
                    r_err <= r_err | i_Error_Flag;
                    r_ph  <= (r_ph == c_check_last) ? '0 : r_ph + c_ph_w'(1);
                end
                c_st_adjust: begin
                    r_err <= 1'b0;
                    if (w_adj_fail) r_fail <= 1'b1;
                    if (w_adj_fail || w_adj_done) begin
                        r_trial       <= w_final;
                        r_div_pending <= w_final;
                    end else begin
                        r_trial       <= w_adj_trial;
                        r_div_pending <= w_adj_trial;
                        if (r_trials != 8'hFF) r_trials <= r_trials + 8'd1;
                    end
`ifdef ACM_BINARY_SEARCH_EN
                    r_lo <= w_lo_n;
                    r_hi <= w_hi_n;
`else
                    if (w_pass) r_best <= r_trial;
`endif
                end
                default: ;
            endcase
        end
    end

    assign o_Clk_Var = r_clk_var;
    assign o_Clk_En  = r_clk_en;
    assign o_Clk_Div = r_div_active;
    assign o_Busy    = (r_state != c_st_idle) && (r_state != c_st_done);
    assign o_Done    = (r_state == c_st_done);
    assign o_Fail    = r_fail;
    assign o_Trials  = r_trials;

endmodule
`default_nettype wire

// File: tb/tb_adaptive_clk_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_adaptive_clk_ctrl
// Purpose  : Self-checking bench for adaptive_clk_ctrl with a threshold error
//            model and an algorithmic reference for the divider search.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adaptive_clk_ctrl;
    localparam int DW     = 8;
    localparam int DMIN   = 0;
    localparam int DMAX   = 15;
    localparam int MARGIN = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_Start = 1'b0;
    logic          i_Error_Flag = 1'b0;
    logic          o_Clk_Var;
    logic          o_Clk_En;
    logic [DW-1:0] o_Clk_Div;
    logic          o_Busy;
    logic          o_Done;
    logic          o_Fail;
    logic [7:0]    o_Trials;

    int n_checks = 0;
    int n_errors = 0;
    int thr = 16;   // active dividers below thr produce comparator errors

    adaptive_clk_ctrl #(
        .DIV_WIDTH(DW), .DIV_MIN(DMIN), .DIV_MAX(DMAX),
        .SETTLE_CYCLES(4), .CHECK_CYCLES(8), .MARGIN(MARGIN)
    ) dut (
        .clk(clk), .rst(rst), .i_Start(i_Start), .i_Error_Flag(i_Error_Flag),
        .o_Clk_Var(o_Clk_Var), .o_Clk_En(o_Clk_En), .o_Clk_Div(o_Clk_Div),
        .o_Busy(o_Busy), .o_Done(o_Done), .o_Fail(o_Fail), .o_Trials(o_Trials)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Search outcome derived directly from the search rules and the threshold model
    function automatic void model(input int t, output int trials, output int div, output bit fail);
        int lo, hi, mid, best;
        trials = 1;
        fail   = 0;
        if (DMAX < t) begin
            fail = 1;
            div  = DMAX;
            return;
        end
`ifdef ACM_BINARY_SEARCH_EN
        lo = DMIN;
        hi = DMAX;
        while (lo < hi) begin
            mid = (lo + hi) / 2;
            trials++;
            if (mid >= t) hi = mid;
            else          lo = mid + 1;
        end
        best = hi;
`else
        best = DMAX;
        for (int d = DMAX - 1; d >= DMIN; d--) begin
            trials++;
            if (d < t) break;
            best = d;
        end
`endif
        div = (best + MARGIN > DMAX) ? DMAX : best + MARGIN;
        if (trials > 255) trials = 255;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_div"},    o_Clk_Div, DMAX);
        check({tag, "_var"},    o_Clk_Var, 1);
        check({tag, "_en"},     o_Clk_En,  0);
        check({tag, "_busy"},   o_Busy,    0);
        check({tag, "_done"},   o_Done,    0);
        check({tag, "_fail"},   o_Fail,    0);
        check({tag, "_trials"}, o_Trials,  0);
    endtask

    task automatic run_search(input int t, input bit poke, input string tag);
        int et, ed, cnt;
        bit ef;
        thr = t;
        model(t, et, ed, ef);
        i_Start = 1'b1;
        @(negedge clk);
        i_Start = 1'b0;
        check({tag, "_busy_start"},   o_Busy,   1);
        check({tag, "_done_start"},   o_Done,   0);
        check({tag, "_trials_start"}, o_Trials, 1);
        if (poke) begin
            repeat (20) @(negedge clk);
            check({tag, "_busy_poke"}, o_Busy, 1);
            i_Start = 1'b1;
            @(negedge clk);
            i_Start = 1'b0;
        end
        cnt = 0;
        while (o_Done !== 1'b1 && cnt < 5000) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_done"},   o_Done,   1);
        check({tag, "_busy"},   o_Busy,   0);
        check({tag, "_trials"}, o_Trials, et);
        check({tag, "_div"},    o_Clk_Div, ed);
        check({tag, "_fail"},   o_Fail,   ef);
        repeat (3) @(negedge clk);
        check({tag, "_done_hold"}, o_Done, 1);
    endtask

    // Comparator model: errors depend only on the active divider while busy
    initial begin
        forever begin
            @(negedge clk);
            if (o_Busy === 1'b1) i_Error_Flag = (int'(o_Clk_Div) < thr);
            else                 i_Error_Flag = 1'($urandom);
        end
    end

    // Every full phase of o_Clk_Var lasts active divider + 1 clocks; divider fixed within a phase
    initial begin
        logic          rst_q;
        logic          cur_var;
        logic [DW-1:0] cur_div;
        int            len;
        cur_var = 1'b1;
        cur_div = DW'(DMAX);
        len     = 0;
        forever begin
            @(posedge clk);
            rst_q = rst;
            @(negedge clk);
            if (rst_q) begin
                cur_var = o_Clk_Var;
                cur_div = o_Clk_Div;
                len     = 1;
            end else if (o_Clk_Var !== cur_var) begin
                check("phase_len", len, int'(cur_div) + 1);
                check("clk_en_edge", o_Clk_En, o_Clk_Var);
                cur_var = o_Clk_Var;
                cur_div = o_Clk_Div;
                len     = 1;
            end else begin
                check("clk_en_quiet", o_Clk_En, 0);
                check("div_stable", o_Clk_Div, cur_div);
                len++;
            end
        end
    end

    initial begin
        int cnt;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        cnt = 0;
        while (o_Clk_En !== 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("clk_en_seen", o_Clk_En, 1);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (o_Clk_En !== 1'b1 && cnt < 100);
        check("period_div15", cnt, 32);

        run_search(5, 1'b0, "thr5");
        run_search(16, 1'b0, "always_err");
        run_search(0, 1'b1, "never_err");
        for (int i = 0; i < 6; i++) run_search(int'($urandom_range(0, 16)), 1'b0, "rand");

        thr = 0;
        i_Start = 1'b1;
        @(negedge clk);
        i_Start = 1'b0;
        cnt = 0;
        while (o_Trials !== 8'd3 && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        check("rst_reach_t3", o_Trials, 3);
        repeat ($urandom_range(2, 12)) @(negedge clk);
        check("rst_busy_before", o_Busy, 1);
        rst     = 1'b1;
        i_Start = 1'b1;
        @(negedge clk);
        check_reset_values("midrst");
        rst     = 1'b0;
        i_Start = 1'b0;
        @(negedge clk);
        check("midrst_idle", o_Busy, 0);
        check("midrst_div15", o_Clk_Div, DMAX);
        run_search(int'($urandom_range(0, 16)), 1'b0, "after_rst");
        run_search(5, 1'b0, "thr5_again");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
